// File: rtl/mkio_bc_scheduler.sv
// mkio_bc_scheduler: bus-controller scheduler that walks a table of BC->RT messages per frame
module mkio_bc_scheduler #(
    parameter int          NUM_MSG   = 4,
    parameter logic [15:0] TIMEOUT   = 16'd1000,
    parameter logic [1:0]  MAX_RETRY = 2'd1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_idx,
    input  logic [15:0]        cfg_cmd,
    input  logic [NUM_MSG-1:0] cfg_en,
    output logic [7:0]         dat_addr,
    input  logic [15:0]        dat_in,
    output logic [15:0]        tx_data,
    output logic               tx_cd,
    output logic               tx_valid,
    input  logic               tx_ack,
    input  logic               rx_done,
    input  logic [15:0]        rx_data,
    input  logic               p_error,
    output logic               busy,
    output logic               frame_done,
    output logic [NUM_MSG-1:0] err_flags,
    output logic [2:0]         cur_slot
);

    typedef enum logic [3:0] {
        S_IDLE, S_NEXT, S_LOAD_CMD, S_SEND_CMD, S_LOAD_DAT, S_LATCH_DAT,
        S_SEND_DAT, S_WAIT, S_CHECK, S_FAIL, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         slot_q, slot_d;
    logic [NUM_MSG-1:0] en_q, en_d, err_q, err_d;
    logic [1:0]         retry_q, retry_d;
    logic [4:0]         wcnt_q, wcnt_d;
    logic [15:0]        tcnt_q, tcnt_d;
    logic [9:0]         cmd_q, cmd_d;
    logic [5:0]         stat_q, stat_d;
    logic               perr_q, perr_d;
    logic [15:0]        tx_data_q, tx_data_d;
    logic               tx_cd_q, tx_cd_d, tx_valid_q, tx_valid_d;
    logic [7:0]         dat_addr_q, dat_addr_d;
    logic               busy_q, busy_d, frame_done_q, frame_done_d;
    logic [15:0]        tbl_q [8];
    logic [NUM_MSG-1:0] slot_bit;
    logic               slot_en, pass;
    logic               unused_rx;

    // cmd_q keeps {rt_addr, word_count}; stat_q keeps {rt_addr, message_error}
    assign slot_bit  = NUM_MSG'(1) << slot_q;
    assign slot_en   = |(en_q & slot_bit);
    assign pass      = !perr_q && stat_q[5:1] == cmd_q[9:5] && !stat_q[0];
    assign unused_rx = ^rx_data[9:0];

    assign dat_addr   = dat_addr_q;
    assign tx_data    = tx_data_q;
    assign tx_cd      = tx_cd_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_flags  = err_q;
    assign cur_slot   = slot_q[2:0];

    // command table: host writes land any time, read only when a command is loaded
    always_ff @(posedge clk) begin
        if (cfg_we) tbl_q[cfg_idx] <= cfg_cmd;
    end

    // frame sequencing: next-state and next-output computation
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        en_d         = en_q;
        err_d        = err_q;
        retry_d      = retry_q;
        wcnt_d       = wcnt_q;
        tcnt_d       = tcnt_q;
        cmd_d        = cmd_q;
        stat_d       = stat_q;
        perr_d       = perr_q;
        tx_data_d    = tx_data_q;
        tx_cd_d      = tx_cd_q;
        tx_valid_d   = tx_valid_q;
        dat_addr_d   = dat_addr_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                en_d    = cfg_en;
                err_d   = '0;
                slot_d  = '0;
                busy_d  = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (slot_q == 4'(NUM_MSG)) state_d = S_DONE;
                else if (!slot_en) slot_d = slot_q + 4'd1;
                else begin
                    retry_d = '0;
                    state_d = S_LOAD_CMD;
                end
            end
            S_LOAD_CMD: begin
                tx_data_d  = tbl_q[slot_q[2:0]];
                cmd_d      = {tbl_q[slot_q[2:0]][15:11], tbl_q[slot_q[2:0]][4:0]};
                tx_cd_d    = 1'b1;
                tx_valid_d = 1'b1;
                wcnt_d     = '0;
                state_d    = S_SEND_CMD;
            end
            S_SEND_CMD: if (tx_ack) begin
                tx_valid_d = 1'b0;
                dat_addr_d = {slot_q[2:0], 5'd0};
                state_d    = S_LOAD_DAT;
            end
            S_LOAD_DAT: state_d = S_LATCH_DAT;
            S_LATCH_DAT: begin
                tx_data_d  = dat_in;
                tx_cd_d    = 1'b0;
                tx_valid_d = 1'b1;
                state_d    = S_SEND_DAT;
            end
            S_SEND_DAT: if (tx_ack) begin
                tx_valid_d = 1'b0;
                // a word count of 0 means 32 words: 0-1 wraps to 31 in 5 bits
                if (wcnt_q == cmd_q[4:0] - 5'd1) begin
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    wcnt_d     = wcnt_q + 5'd1;
                    dat_addr_d = dat_addr_q + 8'd1;
                    state_d    = S_LOAD_DAT;
                end
            end
            S_WAIT: begin
                // a response arriving on the expiry cycle still counts
                if (rx_done) begin
                    stat_d  = rx_data[15:10];
                    perr_d  = p_error;
                    state_d = S_CHECK;
                end else if (tcnt_q == TIMEOUT - 16'd1) state_d = S_FAIL;
                else tcnt_d = tcnt_q + 16'd1;
            end
            S_CHECK: begin
                if (pass) begin
                    slot_d  = slot_q + 4'd1;
                    state_d = S_NEXT;
                end else state_d = S_FAIL;
            end
            S_FAIL: begin
                if (retry_q < MAX_RETRY) begin
                    retry_d = retry_q + 2'd1;
                    state_d = S_LOAD_CMD;
                end else begin
                    err_d   = err_q | slot_bit;
                    slot_d  = slot_q + 4'd1;
                    state_d = S_NEXT;
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and registered outputs; reset aborts any frame immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            en_q         <= '0;
            err_q        <= '0;
            retry_q      <= '0;
            wcnt_q       <= '0;
            tcnt_q       <= '0;
            cmd_q        <= '0;
            stat_q       <= '0;
            perr_q       <= 1'b0;
            tx_data_q    <= '0;
            tx_cd_q      <= 1'b0;
            tx_valid_q   <= 1'b0;
            dat_addr_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            en_q         <= en_d;
            err_q        <= err_d;
            retry_q      <= retry_d;
            wcnt_q       <= wcnt_d;
            tcnt_q       <= tcnt_d;
            cmd_q        <= cmd_d;
            stat_q       <= stat_d;
            perr_q       <= perr_d;
            tx_data_q    <= tx_data_d;
            tx_cd_q      <= tx_cd_d;
            tx_valid_q   <= tx_valid_d;
            dat_addr_q   <= dat_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/mkio_bc_scheduler.md
# mkio_bc_scheduler

Bus-controller-side message scheduler for the MKIO link. On each `start` pulse it walks a table of up to `NUM_MSG` BC→RT (receive) messages. For each enabled slot it:
- sends the command word and its data words through the shared word transmitter;
- waits for the remote terminal's response (status) word, with a timeout;
- validates the response;
- retries on failure, then records a per-slot error flag.

It sits between the host configuration logic, a synchronous data-word RAM, the Manchester TX encoder and the RX decoder.

## Interface
Parameters:
- `NUM_MSG`, 4: number of message slots (1..8); slot index width is 3 bits internally.
- `TIMEOUT`, 16'd1000: clk cycles allowed from end of last TX word to `rx_done`.
- `MAX_RETRY`, 2'd1: retries per message after the first attempt.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; begins a frame.
- `cfg_we` in 1: write strobe for the command table.
- `cfg_idx` in 3: slot written by `cfg_we`.
- `cfg_cmd` in 16: command word.
  - [15:11] RT address, [10] T/R (must be 0), [9:5] subaddress, [4:0] word count (0 = 32).
- `cfg_en` in NUM_MSG: slot enable mask, sampled at `start`.
- `dat_addr` out 8: data RAM read address, {slot[2:0], word[4:0]}.
- `dat_in` in 16: RAM data, valid 1 cycle after `dat_addr`.
- `tx_data` out 16: word to transmit.
- `tx_cd` out 1: 1 = command sync, 0 = data sync.
- `tx_valid` out 1: word request.
- `tx_ack` in 1: encoder accepted word (one-cycle pulse).
- `rx_done` in 1: decoded word available.
- `rx_data` in 16: decoded word.
- `p_error` in 1: parity/Manchester error on `rx_data`, valid with `rx_done`.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `err_flags` out NUM_MSG: per-slot failure; cleared at `start`.
- `cur_slot` out 3: slot being processed.

## Operation
States and transitions:
- **IDLE**: waits for `start`.
  - On `start`: latch `cfg_en`, clear `err_flags`, slot = 0, `busy` = 1, go to NEXT_CHK.
  - `start` while `busy` = 1 is ignored.
- **NEXT_CHK**:
  - slot == NUM_MSG → DONE.
  - Slot disabled → slot+1, stay in NEXT_CHK (1 cycle per skipped slot).
  - Otherwise clear retry counter → LOAD_CMD.
- **LOAD_CMD**: `tx_data` = table[slot], `tx_cd` = 1, `tx_valid` = 1, word counter = 0 → SEND_CMD.
- **SEND_CMD**: hold outputs until `tx_ack`; then `tx_valid` = 0, `dat_addr` = {slot,0} → LOAD_DAT.
- **LOAD_DAT**: 1 wait cycle for RAM → LATCH_DAT.
- **LATCH_DAT**: `tx_data` = `dat_in`, `tx_cd` = 0, `tx_valid` = 1 → SEND_DAT.
- **SEND_DAT**: on `tx_ack`, `tx_valid` = 0.
  - If word counter == count-1 (count 0 ⇒ 31): clear timeout counter → WAIT_RESP.
  - Else word counter+1, `dat_addr`+1 → LOAD_DAT.
- **WAIT_RESP**: timeout counter +1 per cycle.
  - `rx_done` → CHECK (latch `rx_data`, `p_error`).
  - Counter == TIMEOUT-1 without `rx_done` → FAIL.
- **CHECK**: pass iff `p_error` = 0, status[15:11] == cmd[15:11], and status[10] == 0.
  - Pass → slot+1 → NEXT_CHK.
  - Else → FAIL.
- **FAIL**:
  - retry < MAX_RETRY: retry+1 → LOAD_CMD (whole message resent).
  - Else set `err_flags[slot]`, slot+1 → NEXT_CHK.
- **DONE**: `frame_done` = 1 for one cycle, `busy` = 0 → IDLE.

Boundary rules:
- `rx_done` outside WAIT_RESP is ignored.
- `rx_done` in the same cycle the timeout expires counts as a response (rx wins).
- Table writes (`cfg_we`) are accepted in any state. A write to the current slot takes effect at the next LOAD_CMD, including on retry.
- Word counter is 5 bits and wraps only via the count compare; count 0 sends exactly 32 data words.
- Timeout counter is 16 bits; it saturates at TIMEOUT-1 and never wraps.

## Timing
- Reset values:
  - Outputs: `tx_data` = 0, `tx_cd` = 0, `tx_valid` = 0, `busy` = 0, `frame_done` = 0, `err_flags` = 0, `dat_addr` = 0, `cur_slot` = 0.
  - Internal: state IDLE; table contents undefined.
  - Reset mid-frame aborts immediately; `tx_valid` drops asynchronously.
- `start` → `busy` high on the next edge.
- With immediate `tx_ack`: first `tx_valid` (command) 3 cycles after `start`.
- `tx_valid` rises in the cycle after LOAD_CMD/LATCH_DAT and falls the cycle after `tx_ack` is sampled.
- `tx_data` and `tx_cd` are stable while `tx_valid` = 1.
- Per data word, with `tx_ack` in the first SEND cycle: 3 cycles (LOAD_DAT, LATCH_DAT, SEND_DAT).
- `frame_done` asserts 1 cycle after the last slot completes; `err_flags` is valid at `frame_done` and held until the next `start`.

## Test plan
- **Normal message:** slot0 cmd 16'h0822 (addr 1, sa 1, count 2), en = 4'b0001, RAM {0,0} = 16'hA5A5, {0,1} = 16'h5A5A, immediate `tx_ack`, status 16'h0800 20 cycles later.
  - Expect TX sequence 0822(cd=1), A5A5(cd=0), 5A5A(cd=0); `frame_done` pulse; `err_flags` = 0.
- **Timeout with retry:** TIMEOUT = 50, no `rx_done`.
  - Expect command sent twice (MAX_RETRY = 1), 50-cycle gaps, `err_flags[0]` = 1.
- **Bad status:** status 16'h0C00 (bit 10 set), then 16'h1000 (addr 2) on the retry → `err_flags[0]` = 1.
  - Separate run: `p_error` = 1 on the first response, good status on the retry → `err_flags` = 0.
- **Skipping and count 0:** en = 4'b1010, slot3 count 0.
  - Expect slots 0 and 2 skipped, `cur_slot` 1 then 3, exactly 32 data words for slot 3, `dat_addr` 8'h60..8'h7F.
- **Busy start and reset:** `start` while `busy` → no effect on the sequence.
  - `reset` during SEND_DAT → all outputs return to reset values the same cycle; a new `start` runs cleanly from slot 0.
